register_file_wb: RTL and testbench

REGISTER_FILE_WB -- requirements
Module: register_file_wb

---
 rtl/register_file_wb_if.sv | 35 +++
 rtl/register_file_wb.sv | 99 +++++++++
 tb/tb_register_file_wb.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/register_file_wb_if.sv
// Decode / write-back bundle for the register file: write-back port,
// source operand reads, issue request and scoreboard status.
interface register_file_wb_if;
  logic        wb_valid;
  logic [3:0]  reg_address_to_be_written;
  logic [63:0] final_value;
  logic [3:0]  rs_a;
  logic [3:0]  rs_b;
  logic        use_a;
  logic        use_b;
  logic        issue_valid;
  logic [3:0]  issue_dest;
  logic        issue_writes;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;
  logic        stall;
  logic [15:0] pending;
  logic        wb_error;

  // Pipeline side: drives write-back and decode requests, observes results.
  modport master (
    output wb_valid, reg_address_to_be_written, final_value,
    output rs_a, rs_b, use_a, use_b,
    output issue_valid, issue_dest, issue_writes,
    input  rd_data_a, rd_data_b, stall, pending, wb_error
  );

  // Register file side.
  modport slave (
    input  wb_valid, reg_address_to_be_written, final_value,
    input  rs_a, rs_b, use_a, use_b,
    input  issue_valid, issue_dest, issue_writes,
    output rd_data_a, rd_data_b, stall, pending, wb_error
  );
endinterface

// File: rtl/register_file_wb.sv
// 16 x 64-bit register file with write-back bypass and a per-register
// pending scoreboard that stalls decode on RAW / WAW hazards.
// Register 0 is hard-wired to zero and never becomes pending.
module register_file_wb (
  input  logic               clk,
  input  logic               rst_n,
  register_file_wb_if.slave  bus
);

  logic [63:0] regs_q [16];
  logic [63:0] regs_d [16];
  logic [15:0] pending_q;
  logic [15:0] pending_d;
  logic        wb_error_q;
  logic        wb_error_d;

  logic        wb_hit;
  logic [15:0] clear_mask;
  logic [15:0] set_mask;
  logic [15:0] pending_eff;
  logic        raw_a;
  logic        raw_b;
  logic        waw;
  logic        stall_c;
  logic        accept;

  // Hazard detection: a write-back landing this cycle resolves its own
  // pending bit, so the effective scoreboard excludes it.
  always_comb begin
    wb_hit      = bus.wb_valid && (bus.reg_address_to_be_written != 4'd0);
    clear_mask  = wb_hit ? (16'h0001 << bus.reg_address_to_be_written) : '0;
    pending_eff = pending_q & ~clear_mask;
    raw_a       = bus.use_a && pending_eff[bus.rs_a];
    raw_b       = bus.use_b && pending_eff[bus.rs_b];
    waw         = bus.issue_writes && pending_eff[bus.issue_dest];
    // Gating with rst_n keeps stall low while reset is held.
    stall_c     = rst_n && bus.issue_valid && (raw_a || raw_b || waw);
    accept      = bus.issue_valid && !stall_c;
    set_mask    = (accept && bus.issue_writes && (bus.issue_dest != 4'd0))
                  ? (16'h0001 << bus.issue_dest) : '0;
  end

  // Next-state: data write, scoreboard update (set wins over clear), sticky error.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wb_hit) begin
      regs_d[bus.reg_address_to_be_written] = bus.final_value;
    end
    pending_d  = (pending_q & ~clear_mask) | set_mask;
    wb_error_d = wb_error_q
                 | (wb_hit && !pending_q[bus.reg_address_to_be_written]);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
      pending_q  <= '0;
      wb_error_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pending_q  <= pending_d;
      wb_error_q <= wb_error_d;
    end
  end

  // Operand read with same-cycle write-back bypass; r0 always reads zero.
  always_comb begin
    if (!rst_n || bus.rs_a == 4'd0) begin
      bus.rd_data_a = '0;
    end else if (wb_hit && bus.reg_address_to_be_written == bus.rs_a) begin
      bus.rd_data_a = bus.final_value;
    end else begin
      bus.rd_data_a = regs_q[bus.rs_a];
    end

    if (!rst_n || bus.rs_b == 4'd0) begin
      bus.rd_data_b = '0;
    end else if (wb_hit && bus.reg_address_to_be_written == bus.rs_b) begin
      bus.rd_data_b = bus.final_value;
    end else begin
      bus.rd_data_b = regs_q[bus.rs_b];
    end
  end

  // Status outputs.
  always_comb begin
    bus.stall    = stall_c;
    bus.pending  = pending_q;
    bus.wb_error = wb_error_q;
  end

endmodule

// File: tb/tb_register_file_wb.sv
// Scoreboard bench for register_file_wb: directed scenarios then random
// traffic, expected outputs from a behavioural array model.
module tb_register_file_wb;

  logic clk;
  logic rst_n;
  register_file_wb_if bus();

  register_file_wb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        stall;
    logic [15:0] pend;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [63:0] m_mem [16];
  bit          m_pend [16];
  bit          m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_data_a", bus.rd_data_a, e.a);
        chk("rd_data_b", bus.rd_data_b, e.b);
        chk("stall",     64'(bus.stall), 64'(e.stall));
        chk("pending",   64'(bus.pending), 64'(e.pend));
        chk("wb_error",  64'(bus.wb_error), 64'(e.err));
      end
    end
  end

  function automatic logic [15:0] pend_vec();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One cycle: apply inputs just after the rising edge, predict, advance model.
  task automatic step(input bit rst, input bit wbv, input logic [3:0] wa,
                      input logic [63:0] fv, input logic [3:0] ra, input logic [3:0] rb,
                      input bit ua, input bit ub, input bit iv,
                      input logic [3:0] id, input bit iw);
    exp_t e;
    bit   landing, blocked, stl;
    @(posedge clk);
    #1;
    rst_n = rst;
    bus.wb_valid = wbv; bus.reg_address_to_be_written = wa; bus.final_value = fv;
    bus.rs_a = ra; bus.rs_b = rb; bus.use_a = ua; bus.use_b = ub;
    bus.issue_valid = iv; bus.issue_dest = id; bus.issue_writes = iw;

    landing = rst && wbv && (wa != 0);
    // A register is blocking if pending and not being written back right now.
    blocked = 0;
    if (ua && m_pend[ra] && !(landing && wa == ra)) blocked = 1;
    if (ub && m_pend[rb] && !(landing && wa == rb)) blocked = 1;
    if (iw && m_pend[id] && !(landing && wa == id)) blocked = 1;
    stl = rst && iv && blocked;

    e.a     = (!rst || ra == 0) ? 64'd0 : ((landing && wa == ra) ? fv : m_mem[ra]);
    e.b     = (!rst || rb == 0) ? 64'd0 : ((landing && wa == rb) ? fv : m_mem[rb]);
    e.stall = stl;
    e.pend  = rst ? pend_vec() : 16'h0;
    e.err   = rst ? m_err : 1'b0;
    sb.push_back(e);

    if (!rst) begin
      for (int i = 0; i < 16; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
      m_err = 0;
    end else begin
      if (landing) begin
        if (!m_pend[wa]) m_err = 1;
        m_mem[wa]  = fv;
        m_pend[wa] = 0;
      end
      if (iv && !stl && iw && id != 0) m_pend[id] = 1;
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue(input logic [3:0] d);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, d, 1);
  endtask

  task automatic wb(input logic [3:0] a, input logic [63:0] v);
    step(1, 1, a, v, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic random_block(input int n);
    logic [3:0] wa, ra, rb, id;
    bit wbv;
    for (int c = 0; c < n; c++) begin
      wbv = ($urandom_range(0, 9) < 5);
      wa  = 4'($urandom_range(0, 15));
      // Mostly retire registers that are actually pending.
      if ($urandom_range(0, 9) < 8) begin
        for (int k = 0; k < 16; k++) begin
          if (m_pend[(int'(wa) + k) % 16]) begin
            wa = 4'((int'(wa) + k) % 16);
            break;
          end
        end
      end
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      id = 4'($urandom_range(0, 15));
      step(1, wbv, wa, {$urandom, $urandom}, ra, rb,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 7), id, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
    m_err = 0;
    rst_n = 1'b0;
    bus.wb_valid = 0; bus.reg_address_to_be_written = 0; bus.final_value = 0;
    bus.rs_a = 0; bus.rs_b = 0; bus.use_a = 0; bus.use_b = 0;
    bus.issue_valid = 0; bus.issue_dest = 0; bus.issue_writes = 0;

    // Reset held, with traffic that must be ignored
    step(0, 1, 5, 64'h55, 5, 5, 1, 1, 1, 5, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Write then read back
    issue(5);
    wb(5, 64'h0B);
    step(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0);

    // Same-cycle bypass on port b
    issue(3);
    step(1, 1, 3, 64'h8, 0, 3, 0, 1, 0, 0, 0);
    idle();

    // RAW stall on 7, resolved by write-back in the same cycle
    issue(7);
    step(1, 0, 0, 0, 7, 0, 1, 0, 1, 0, 0);
    step(1, 1, 7, 64'hE, 7, 0, 1, 0, 1, 0, 0);
    idle();

    // Set wins over clear; then WAW stall
    issue(4);
    step(1, 1, 4, 64'h44, 0, 0, 0, 0, 1, 4, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1);
    step(1, 0, 0, 0, 4, 4, 1, 1, 0, 0, 0);
    wb(4, 64'h4444);

    // Several pending at once, independent bits
    issue(1); issue(2); issue(15);
    step(1, 1, 2, 64'h22, 1, 15, 1, 1, 1, 0, 0);
    wb(1, 64'h11); wb(15, 64'hFF00);
    step(1, 0, 0, 0, 1, 15, 0, 0, 0, 0, 0);

    // Unsolicited write-back: sticky error, data still written; r0 ignores writes
    wb(9, 64'h99);
    step(1, 1, 0, 64'hFF, 0, 9, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 9, 0, 0, 1, 0, 1);

    // Asynchronous reset mid-operation
    issue(2); issue(6);
    step(0, 1, 6, 64'h66, 2, 9, 1, 1, 1, 8, 1);
    step(1, 0, 0, 0, 2, 6, 1, 1, 0, 0, 0);

    // Random traffic in blocks separated by resets
    for (int b = 0; b < 3; b++) begin
      random_block(300);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
